// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying an opaque payload between pipeline stages.
// The master drives valid/data and the slave returns ready.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 160
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with an optional skid entry, synchronous flush
// and a saturating backpressure counter.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no entry held (main_v=0, skid_v=0)
// ST_FULL  | main entry held, skid free (main_v=1, skid_v=0)
// ST_SKID  | main and skid both held; only reachable with SKID_EN=1
module pipe_stage_skid #(
   parameter int DATA_W  = 160,
   parameter bit SKID_EN = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   pipe_stage_skid_if.slave     up_if,
   pipe_stage_skid_if.master    dn_if,
   output logic [1:0]           occupancy_o,
   output logic [CNT_W-1:0]     stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                main_v;
   logic                skid_v;
   logic                in_ready;
   logic                in_xfer;
   logic                out_xfer;

   assign main_v = (state_q != ST_EMPTY);
   assign skid_v = (state_q == ST_SKID);

   // With the skid entry, ready depends only on flops so it can cut the upstream path.
   generate
      if (SKID_EN) begin : g_rdy_skid
         assign in_ready = !skid_v && !rst_i;
      end else begin : g_rdy_single
         assign in_ready = (!main_v || dn_if.ready) && !rst_i;
      end
   endgenerate

   assign in_xfer  = up_if.valid && in_ready;
   assign out_xfer = main_v && dn_if.ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               main_d  = up_if.data;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (in_xfer && (out_xfer || !SKID_EN)) begin
               main_d  = up_if.data;
               state_d = ST_FULL;
            end else if (in_xfer) begin
               skid_d  = up_if.data;
               state_d = ST_SKID;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (out_xfer) begin
               main_d  = skid_q;
               state_d = ST_FULL;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      // Flush drops the valid bits only; payload registers keep their old contents.
      if (flush_i) begin
         state_d = ST_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (main_v && !dn_if.ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         cnt_q   <= cnt_d;
      end
   end

   generate
      if (SKID_EN) begin : g_skid
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               skid_q <= '0;
            end else begin
               skid_q <= skid_d;
            end
         end
      end else begin : g_no_skid
         assign skid_q = '0;
      end
   endgenerate

   assign up_if.ready = in_ready;
   assign dn_if.valid = main_v;
   assign dn_if.data  = main_q;
   assign occupancy_o = {1'b0, main_v} + {1'b0, skid_v};
   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives a skid-enabled and a single-entry stage with identical stimulus and checks
// both against a queue-based reference model.
module tb_pipe_stage_skid;
   localparam int DW = 160;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, flush, iv, ordy;
   logic [DW-1:0] pay;

   pipe_stage_skid_if #(.DATA_W(DW)) u0 ();
   pipe_stage_skid_if #(.DATA_W(DW)) d0 ();
   pipe_stage_skid_if #(.DATA_W(DW)) u1 ();
   pipe_stage_skid_if #(.DATA_W(DW)) d1 ();

   logic [1:0]  occ0, occ1;
   logic [2:0]  cnt0;
   logic [15:0] cnt1;

   assign u0.valid = iv;
   assign u0.data  = pay;
   assign d0.ready = ordy;
   assign u1.valid = iv;
   assign u1.data  = pay;
   assign d1.ready = ordy;

   pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(3)) dut0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .up_if(u0.slave), .dn_if(d0.master),
      .occupancy_o(occ0), .stall_cnt_o(cnt0)
   );

   pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b0), .CNT_W(16)) dut1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .up_if(u1.slave), .dn_if(d1.master),
      .occupancy_o(occ1), .stall_cnt_o(cnt1)
   );

   logic          act_rdy [2];
   logic          act_v   [2];
   logic [1:0]    act_occ [2];
   logic [15:0]   act_cnt [2];
   logic [DW-1:0] act_d   [2];

   assign act_rdy[0] = u0.ready;
   assign act_rdy[1] = u1.ready;
   assign act_v[0]   = d0.valid;
   assign act_v[1]   = d1.valid;
   assign act_occ[0] = occ0;
   assign act_occ[1] = occ1;
   assign act_cnt[0] = {13'd0, cnt0};
   assign act_cnt[1] = cnt1;
   assign act_d[0]   = d0.data;
   assign act_d[1]   = d1.data;

   // Reference model: a bounded FIFO per instance plus a saturating stall tally.
   logic [DW-1:0] mq [2][$];
   int            cap   [2];
   int            cmax  [2];
   int            mcnt  [2];
   bit            zflag [2];
   int            max_occ [2];

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic bit exp_ready(input int k);
      if (rst) return 1'b0;
      if (cap[k] == 2) return (mq[k].size() < 2);
      return (mq[k].size() == 0) || ordy;
   endfunction

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("in_ready%0d", k), 256'(act_rdy[k]), 256'(exp_ready(k)));
         chk($sformatf("out_valid%0d", k), 256'(act_v[k]), 256'(mq[k].size() > 0));
         chk($sformatf("occupancy%0d", k), 256'(act_occ[k]), 256'(mq[k].size()));
         chk($sformatf("stall_cnt%0d", k), 256'(act_cnt[k]), 256'(mcnt[k]));
         if (mq[k].size() > 0)
            chk($sformatf("out_data%0d", k), 256'(act_d[k]), 256'(mq[k][0]));
         else if (zflag[k])
            chk($sformatf("rst_data%0d", k), 256'(act_d[k]), 256'(0));
      end
   endtask

   task automatic update_model();
      for (int k = 0; k < 2; k++) begin
         bit in_x, out_x;
         in_x  = iv && exp_ready(k);
         out_x = (mq[k].size() > 0) && ordy;
         if (rst) begin
            mq[k].delete();
            mcnt[k]  = 0;
            zflag[k] = 1'b1;
         end else begin
            if ((mq[k].size() > 0) && !ordy && (mcnt[k] < cmax[k])) mcnt[k]++;
            if (flush) begin
               mq[k].delete();
            end else begin
               if (out_x) void'(mq[k].pop_front());
               if (in_x) begin
                  mq[k].push_back(pay);
                  zflag[k] = 1'b0;
               end
            end
         end
         if (mq[k].size() > max_occ[k]) max_occ[k] = mq[k].size();
      end
   endtask

   initial begin
      bit hi_ready;
      cap[0] = 2;  cmax[0] = 7;
      cap[1] = 1;  cmax[1] = 65535;
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; zflag[k] = 1'b1; max_occ[k] = 0;
      end
      rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; pay = '0;
      hi_ready = 1'b1;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         rst = 1'b0; flush = 1'b0;
         if (cyc < 2) begin
            rst = 1'b1; iv = 1'b0; ordy = 1'b0;
         end else if (cyc < 14) begin
            iv = 1'b1; ordy = 1'b1; pay = DW'(cyc - 2);
         end else if (cyc < 26) begin
            iv = 1'b1; ordy = 1'b0; pay = DW'(100 + cyc);
         end else if (cyc == 26) begin
            flush = 1'b1; iv = 1'b1; ordy = 1'b0; pay = DW'(16'hD00D);
         end else if (cyc < 30) begin
            iv = 1'b0; ordy = 1'b1;
         end else if (cyc < 36) begin
            iv = 1'b1; ordy = 1'b0; pay = DW'(200 + cyc);
         end else if (cyc == 36) begin
            rst = 1'b1; iv = 1'b1; ordy = 1'b0;
         end else begin
            if ((cyc % 32) == 0) hi_ready = !hi_ready;
            rst   = ($urandom_range(79) == 0);
            flush = ($urandom_range(15) == 0);
            iv    = ($urandom_range(3) != 0);
            ordy  = hi_ready ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            pay   = {$urandom, $urandom, $urandom, $urandom, 32'(cyc)};
         end
         @(negedge clk);
         check_all();
         if (cyc == 25) chk("skid_sat_cnt", 256'(act_cnt[0]), 256'(7));
         if (cyc == 14) chk("stream_max_occ", 256'(max_occ[1] + max_occ[0]), 256'(2));
         @(posedge clk);
         update_model();
         #1;
      end
      chk("single_max_occ", 256'(max_occ[1]), 256'(1));
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
